// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame geometry.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/transmitter_parityGen.sv
// Even-parity generator: the parity bit makes the total count of ones in
// data plus parity even. Forced low when parity is disabled.
module transmitter_parityGen (
    input  logic [7:0] data,
    input  logic       parity_en,
    output logic       parity_bit
);

    assign parity_bit = parity_en & (^data);

endmodule

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts clock cycles and pulses tick on the last cycle of
// each serial bit. Held at zero while clear is high so every bit period starts
// from a known phase.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == TERM_CNT) && !clear;

    // Count up to the terminal value, then wrap on the same edge the bit advances.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts one byte via valid/ready, then emits
// start bit, 8 data bits LSB first, optional even parity bit and one stop bit.
// tx_o and tx_done_o are registered so the serial line never glitches.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       parity_en_i,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_o
);

    tx_state_t              state;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   data_lat;
    logic                   par_en;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   baud_clear;
    logic                   baud_tick;
    logic                   parity_bit;
    logic                   tx_q;
    logic                   done_q;

    assign tx_ready_o = (state == IDLE);
    assign tx_busy_o  = (state != IDLE);
    assign tx_o       = tx_q;
    assign tx_done_o  = done_q;

    // Baud timer is parked while idle, so it starts at zero on the cycle after acceptance.
    assign baud_clear = (state == IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .n_rst(n_rst),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    // Parity works from the untouched latched byte, since shift_reg is consumed as bits go out.
    transmitter_parityGen u_parity (
        .data      (data_lat),
        .parity_en (par_en),
        .parity_bit(parity_bit)
    );

    // Frame sequencer; tx_q is loaded with the level of the bit about to start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            data_lat  <= '0;
            par_en    <= 1'b0;
            bit_cnt   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_valid_i) begin
                        shift_reg <= tx_data_i;
                        data_lat  <= tx_data_i;
                        par_en    <= parity_en_i;
                        bit_cnt   <= '0;
                        tx_q      <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tx_q  <= shift_reg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
                            if (par_en) begin
                                tx_q  <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            tx_q <= shift_reg[1];
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        tx_q  <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        tx_q   <= 1'b1;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT = 4.
module tb_uart_tx_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       parity_en_i = 1'b0;
    logic       tx_ready_o;
    logic       tx_o;
    logic       tx_busy_o;
    logic       tx_done_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .parity_en_i(parity_en_i),
        .tx_o       (tx_o),
        .tx_busy_o  (tx_busy_o),
        .tx_done_o  (tx_done_o)
    );

    // Offers one byte, then records tx_o for cycles k+1..k+63 after acceptance edge k.
    task automatic run_frame(input logic [7:0] d, input logic p, input logic disturb,
                             output logic [63:1] cap, output int done_c, output int done_n,
                             output int ready_n, output int busy_n);
        int flen;
        flen = p ? 11 * N : 10 * N;
        cap = '0; done_c = 0; done_n = 0; ready_n = 0; busy_n = 0;
        @(negedge clk);
        tx_data_i = d; parity_en_i = p; tx_valid_i = 1'b1;
        @(posedge clk);
        #1 tx_valid_i = 1'b0;
        for (int c = 1; c <= 63; c++) begin
            @(negedge clk);
            cap[c] = tx_o;
            if (tx_done_o) begin
                done_n++;
                if (done_c == 0) done_c = c;
            end
            if (c <= flen) begin
                if (tx_ready_o) ready_n++;
                if (tx_busy_o) busy_n++;
            end
            if (disturb) begin
                if (c == 6) begin tx_data_i = 8'hFF; parity_en_i = ~p; end
                if (c == 12) tx_valid_i = 1'b1;
                if (c == 13) tx_valid_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_o, tx_ready_o, tx_busy_o, tx_done_o} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_in got=%b want=1100", {tx_o, tx_ready_o, tx_busy_o, tx_done_o});
        end
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({tx_o, tx_ready_o, tx_busy_o, tx_done_o} !== 4'b1100) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b want=1100", i, {tx_o, tx_ready_o, tx_busy_o, tx_done_o});
            end
        end
    endtask

    task automatic test_frame_a5();
        logic [63:1] cap; int done_c, done_n, ready_n, busy_n;
        logic [0:10] exp;
        exp = 11'b01010010111;
        run_frame(8'hA5, 1'b0, 1'b0, cap, done_c, done_n, ready_n, busy_n);
        for (int j = 0; j <= 10; j++) begin
            checks++;
            if (cap[j*N+1 +: N] !== {N{exp[j]}}) begin
                failures++;
                $display("FAIL a5_bit%0d got=%b want=%b", j, cap[j*N+1 +: N], {N{exp[j]}});
            end
        end
        checks++;
        if (cap[63:45] !== '1) begin failures++; $display("FAIL a5_idle got=%b", cap[63:45]); end
        checks++;
        if (done_c !== 41 || done_n !== 1) begin
            failures++; $display("FAIL a5_done at=%0d n=%0d want at=41 n=1", done_c, done_n);
        end
        checks++;
        if (ready_n !== 0 || busy_n !== 40) begin
            failures++; $display("FAIL a5_ready_busy ready=%0d busy=%0d want 0/40", ready_n, busy_n);
        end
    endtask

    task automatic test_parity();
        logic [63:1] cap; int done_c, done_n, ready_n, busy_n;
        logic [0:10] exp;
        exp = 11'b01110000011;
        run_frame(8'h07, 1'b1, 1'b0, cap, done_c, done_n, ready_n, busy_n);
        for (int j = 0; j <= 10; j++) begin
            checks++;
            if (cap[j*N+1 +: N] !== {N{exp[j]}}) begin
                failures++;
                $display("FAIL p07_bit%0d got=%b want=%b", j, cap[j*N+1 +: N], {N{exp[j]}});
            end
        end
        checks++;
        if (done_c !== 45 || done_n !== 1) begin
            failures++; $display("FAIL p07_done at=%0d n=%0d want at=45 n=1", done_c, done_n);
        end
        checks++;
        if (busy_n !== 44) begin failures++; $display("FAIL p07_busy got=%0d want=44", busy_n); end
        exp = 11'b01100000001;
        run_frame(8'h03, 1'b1, 1'b0, cap, done_c, done_n, ready_n, busy_n);
        for (int j = 0; j <= 10; j++) begin
            checks++;
            if (cap[j*N+1 +: N] !== {N{exp[j]}}) begin
                failures++;
                $display("FAIL p03_bit%0d got=%b want=%b", j, cap[j*N+1 +: N], {N{exp[j]}});
            end
        end
        checks++;
        if (done_c !== 45) begin failures++; $display("FAIL p03_done at=%0d want=45", done_c); end
    endtask

    task automatic test_ignore_busy();
        logic [63:1] cap; int done_c, done_n, ready_n, busy_n;
        logic [0:10] exp;
        exp = 11'b01010010111;
        run_frame(8'hA5, 1'b0, 1'b1, cap, done_c, done_n, ready_n, busy_n);
        for (int j = 0; j <= 10; j++) begin
            checks++;
            if (cap[j*N+1 +: N] !== {N{exp[j]}}) begin
                failures++;
                $display("FAIL dist_bit%0d got=%b want=%b", j, cap[j*N+1 +: N], {N{exp[j]}});
            end
        end
        checks++;
        if (cap[63:45] !== '1) begin failures++; $display("FAIL dist_idle got=%b", cap[63:45]); end
        checks++;
        if (done_c !== 41 || done_n !== 1) begin
            failures++; $display("FAIL dist_done at=%0d n=%0d want at=41 n=1", done_c, done_n);
        end
        checks++;
        if (ready_n !== 0) begin failures++; $display("FAIL dist_ready got=%0d want=0", ready_n); end
    endtask

    task automatic test_back_to_back();
        logic [100:1] cap;
        logic [0:9] e1, e2;
        int done_n, d1, d2;
        logic rdy41;
        e1 = 10'b0101010101;
        e2 = 10'b0010101011;
        done_n = 0; d1 = 0; d2 = 0; rdy41 = 1'b0; cap = '0;
        @(negedge clk);
        tx_data_i = 8'h55; parity_en_i = 1'b0; tx_valid_i = 1'b1;
        @(posedge clk);
        #1 tx_data_i = 8'hAA;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            cap[c] = tx_o;
            if (c == 41) rdy41 = tx_ready_o;
            if (tx_done_o) begin
                done_n++;
                if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
            end
            if (c == 42) tx_valid_i = 1'b0;
        end
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (cap[j*N+1 +: N] !== {N{e1[j]}}) begin
                failures++; $display("FAIL b2b_first_bit%0d got=%b want=%b", j, cap[j*N+1 +: N], {N{e1[j]}});
            end
            checks++;
            if (cap[j*N+42 +: N] !== {N{e2[j]}}) begin
                failures++; $display("FAIL b2b_second_bit%0d got=%b want=%b", j, cap[j*N+42 +: N], {N{e2[j]}});
            end
        end
        checks++;
        if (cap[41] !== 1'b1 || rdy41 !== 1'b1) begin
            failures++; $display("FAIL b2b_gap tx=%b ready=%b want 1/1", cap[41], rdy41);
        end
        checks++;
        if (cap[100:82] !== '1) begin failures++; $display("FAIL b2b_tail got=%b", cap[100:82]); end
        checks++;
        if (done_n !== 2 || d1 !== 41 || d2 !== 82) begin
            failures++; $display("FAIL b2b_done n=%0d at=%0d,%0d want 2 at 41,82", done_n, d1, d2);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:1] cap; int done_c, done_n, ready_n, busy_n;
        logic [0:10] exp;
        int bad;
        @(negedge clk);
        tx_data_i = 8'hF0; parity_en_i = 1'b0; tx_valid_i = 1'b1;
        @(posedge clk);
        #1 tx_valid_i = 1'b0;
        repeat (17) @(negedge clk);
        checks++;
        if (tx_o !== 1'b0 || tx_busy_o !== 1'b1) begin
            failures++; $display("FAIL rmid_pre tx=%b busy=%b want 0/1", tx_o, tx_busy_o);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({tx_o, tx_ready_o, tx_busy_o, tx_done_o} !== 4'b1100) begin
            failures++; $display("FAIL rmid_async got=%b want=1100", {tx_o, tx_ready_o, tx_busy_o, tx_done_o});
        end
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_done_o !== 1'b0 || tx_o !== 1'b1 || tx_busy_o !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL rmid_quiet bad_cycles=%0d want=0", bad); end
        exp = 11'b00011110011;
        run_frame(8'h3C, 1'b0, 1'b0, cap, done_c, done_n, ready_n, busy_n);
        for (int j = 0; j <= 10; j++) begin
            checks++;
            if (cap[j*N+1 +: N] !== {N{exp[j]}}) begin
                failures++;
                $display("FAIL r3c_bit%0d got=%b want=%b", j, cap[j*N+1 +: N], {N{exp[j]}});
            end
        end
        checks++;
        if (done_c !== 41 || done_n !== 1) begin
            failures++; $display("FAIL r3c_done at=%0d n=%0d want at=41 n=1", done_c, done_n);
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_parity();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
